// File: rtl/pwm_capture_pkg.sv
// Shared codes for the PWM capture block: bus constants, register map, FSM states.
// Latency: n/a (definitions only); backpressure: n/a.
package pwm_capture_pkg;

  localparam logic        RST_ENABLE   = 1'b0;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  localparam logic [3:0] GRP_PERIOD = 4'h0;
  localparam logic [3:0] GRP_HIGH   = 4'h1;
  localparam logic [3:0] GRP_CSR    = 4'h2;

  localparam logic [3:0] CSR_CTRL   = 4'h0;
  localparam logic [3:0] CSR_STATUS = 4'h1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_t;

  function automatic logic [31:0] reg_addr(input logic [3:0] grp, input logic [3:0] ch);
    return {8'h00, grp, ch, 16'h0000};
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Peripheral bus bundle: write strobe, byte address, write data, combinational read data.
// Latency: reads are combinational; backpressure: none, every access completes in one cycle.
interface pwm_capture_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, output addr_i, output data_i, input data_o);
  modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/pwm_capture_chan.sv
// One capture channel: synchroniser, edge detect, period/high-time FSM with timeout.
// Latency: 3 clk from pin rise to period/high/cap_pulse; backpressure: none.
module pwm_capture_chan
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pin,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high,
  output logic             cap_pulse,
  output logic             timeout_pulse
);

  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s_meta, s_sync, s_q;
  logic rise, fall;
  cap_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;

  assign rise    = s_sync & ~s_q;
  assign fall    = ~s_sync & s_q;
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_q    <= 1'b0;
      state  <= ST_IDLE;
      cnt    <= '0;
      hcnt   <= '0;
      period <= '0;
      high   <= '0;
    end else begin
      s_meta <= pin;
      s_sync <= s_meta;
      s_q    <= s_sync;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hcnt   <= hcnt_nxt;
      if (cap_pulse) begin
        period <= cnt;
        high   <= hcnt;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hcnt_nxt      = hcnt;
    cap_pulse     = 1'b0;
    timeout_pulse = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (rise) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (cnt >= TMO_CNT) begin
          timeout_pulse = 1'b1;
          state_nxt     = ST_IDLE;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (fall) begin
            hcnt_nxt  = cnt;
            state_nxt = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        // A completed period wins over a timeout landing on the same cycle.
        if (rise) begin
          cap_pulse = 1'b1;
          state_nxt = ST_HIGH;
          cnt_nxt   = CNT_ONE;
        end else if (cnt >= TMO_CNT) begin
          timeout_pulse = 1'b1;
          state_nxt     = ST_IDLE;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Disable parks the FSM but lets a capture on this cycle land.
    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Bus-mapped multi-channel PWM input capture: per-channel period/high results, CTRL, W1C STATUS.
// Latency: reads combinational, writes take effect next cycle; backpressure: none.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  pwm_capture_if.slave   bus,
  input  logic [NCH-1:0] pwm_in
);

  logic [CNT_W-1:0] period_r [NCH];
  logic [CNT_W-1:0] high_r   [NCH];
  logic [NCH-1:0]   cap_set, tmo_set;
  logic [NCH-1:0]   ctrl, valid, tmo;
  logic [NCH-1:0]   vld_clr, tmo_clr;
  logic [3:0]       grp, ch;
  logic             wr_csr, ctrl_we, sts_we;
  logic [31:0]      rd_dat;
  logic             unused_ok;

  assign grp     = bus.addr_i[23:20];
  assign ch      = bus.addr_i[19:16];
  assign wr_csr  = (bus.we_i == WRITE_ENABLE) && (grp == GRP_CSR);
  assign ctrl_we = wr_csr && (ch == CSR_CTRL);
  assign sts_we  = wr_csr && (ch == CSR_STATUS);
  assign vld_clr = sts_we ? bus.data_i[NCH-1:0] : '0;
  assign tmo_clr = sts_we ? bus.data_i[NCH+3:4] : '0;
  assign unused_ok = ^{bus.addr_i, bus.data_i};

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pwm_capture_chan #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .en            (ctrl[i]),
      .pin           (pwm_in[i]),
      .period        (period_r[i]),
      .high          (high_r[i]),
      .cap_pulse     (cap_set[i]),
      .timeout_pulse (tmo_set[i])
    );
  end

  // Hardware set is OR'd after the clear so it wins a same-cycle W1C.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      ctrl  <= '0;
      valid <= '0;
      tmo   <= '0;
    end else begin
      if (ctrl_we) begin
        ctrl <= bus.data_i[NCH-1:0];
      end
      valid <= (valid & ~vld_clr) | cap_set;
      tmo   <= (tmo & ~tmo_clr) | tmo_set;
    end
  end

  always_comb begin
    rd_dat = ZERO_WORD;
    case (grp)
      GRP_PERIOD: begin
        for (int i = 0; i < NCH; i++) begin
          if (ch == 4'(i)) rd_dat = 32'(period_r[i]);
        end
      end
      GRP_HIGH: begin
        for (int i = 0; i < NCH; i++) begin
          if (ch == 4'(i)) rd_dat = 32'(high_r[i]);
        end
      end
      GRP_CSR: begin
        if (ch == CSR_CTRL) begin
          rd_dat = 32'(ctrl);
        end else if (ch == CSR_STATUS) begin
          rd_dat = {24'h0, 4'(tmo), 4'(valid)};
        end
      end
      default: rd_dat = ZERO_WORD;
    endcase
  end

  assign bus.data_o = rd_dat;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: reads push expectations, a negedge monitor pops and compares.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam logic [31:0] A_CTRL   = 32'h0020_0000;
  localparam logic [31:0] A_STATUS = 32'h0021_0000;

  logic       clk;
  logic       rst;
  logic [3:0] pins = '0;
  logic       rd_vld = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q  [$];
  logic [31:0] mask_q [$];
  string       name_q [$];

  int mode     [4];
  int hi_len   [4];
  int lo_len   [4];
  int ph       [4];
  int rise_cnt [4];

  pwm_capture_if bus ();

  pwm_capture #(
    .NCH     (4),
    .CNT_W   (32),
    .TIMEOUT (100)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pwm_in (pins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] a_per(input int c);
    return {8'h00, 4'h0, 4'(c), 16'h0000};
  endfunction

  function automatic logic [31:0] a_hi(input int c);
    return {8'h00, 4'h1, 4'(c), 16'h0000};
  endfunction

  // Waveform generator: mode 0 hold low, 1 toggle hi/lo, 2 hold high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (mode[c] == 1) begin
          if (ph[c] == 0) begin
            if (!pins[c]) rise_cnt[c]++;
            pins[c] = 1'b1;
          end else if (ph[c] == hi_len[c]) begin
            pins[c] = 1'b0;
          end
          ph[c] = (ph[c] + 1 == hi_len[c] + lo_len[c]) ? 0 : ph[c] + 1;
        end else begin
          if (mode[c] == 2 && !pins[c]) rise_cnt[c]++;
          pins[c] = (mode[c] == 2);
          ph[c]   = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] e, m, got;
    string nm;
    forever begin
      @(negedge clk);
      if (rd_vld) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: read with no expectation, data %h", bus.data_o);
        end else begin
          e   = exp_q.pop_front();
          m   = mask_q.pop_front();
          nm  = name_q.pop_front();
          got = bus.data_o & m;
          n_tests++;
          if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.data_i = d;
    @(posedge clk);
    #1;
    bus.we_i   = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] m, input logic [31:0] e,
                        input string nm);
    @(posedge clk);
    #1;
    bus.addr_i = a;
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
    rd_vld = 1'b1;
    @(posedge clk);
    #1;
    rd_vld = 1'b0;
  endtask

  task automatic wait_rise(input int c, input int n, input int budget, input string nm);
    int t = 0;
    while (rise_cnt[c] < n && t < budget) begin
      #1;
      t++;
    end
    if (rise_cnt[c] < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: rise count %0d, required %0d", nm, rise_cnt[c], n);
    end
  endtask

  initial begin
    int base;
    rst        = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = '0;
    bus.data_i = '0;

    // Reset state
    rd_chk(a_per(0), 32'hFFFF_FFFF, 32'h0, "rst_period0");
    rd_chk(a_hi(0),  32'hFFFF_FFFF, 32'h0, "rst_high0");
    rd_chk(A_CTRL,   32'hFFFF_FFFF, 32'h0, "rst_ctrl");
    rd_chk(A_STATUS, 32'hFFFF_FFFF, 32'h0, "rst_status");
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Basic capture on ch0, 3 high / 7 low, with edge-exact latency probe
    wr(A_CTRL, 32'h1);
    hi_len[0] = 3;
    lo_len[0] = 7;
    mode[0]   = 1;
    wait_rise(0, 2, 1000, "basic_rise");
    bus.addr_i = A_STATUS;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back((k == 3) ? 32'h1 : 32'h0);
      mask_q.push_back(32'h1);
      name_q.push_back($sformatf("latency_edge%0d", k));
    end
    rd_vld = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd_vld = 1'b0;
    rd_chk(a_per(0), 32'hFFFF_FFFF, 32'd10, "basic_period0");
    rd_chk(a_hi(0),  32'hFFFF_FFFF, 32'd3,  "basic_high0");

    // Multi-channel, unmapped/read-only accesses, W1C
    wr(A_CTRL, 32'hB);
    hi_len[1] = 25; lo_len[1] = 25; mode[1] = 1;
    hi_len[3] = 1;  lo_len[3] = 3;  mode[3] = 1;
    wait_rise(1, 3, 5000, "multi_rise1");
    wait_rise(3, 3, 1000, "multi_rise3");
    rd_chk(a_per(1), 32'hFFFF_FFFF, 32'd50, "multi_period1");
    rd_chk(a_hi(1),  32'hFFFF_FFFF, 32'd25, "multi_high1");
    rd_chk(a_per(3), 32'hFFFF_FFFF, 32'd4,  "multi_period3");
    rd_chk(a_hi(3),  32'hFFFF_FFFF, 32'd1,  "multi_high3");
    rd_chk(A_STATUS, 32'h0000_000F, 32'hB,  "multi_valid");
    rd_chk(A_CTRL,   32'hFFFF_FFFF, 32'hB,  "ctrl_readback");
    wr(a_per(3), 32'h0000_FFFF);
    rd_chk(a_per(3), 32'hFFFF_FFFF, 32'd4,  "ro_write_ignored");
    rd_chk(32'h0030_0000, 32'hFFFF_FFFF, 32'h0, "unmapped_grp3");
    rd_chk(32'h0022_0000, 32'hFFFF_FFFF, 32'h0, "unmapped_csr2");
    mode[1] = 0;
    cycles(5);
    wr(A_STATUS, 32'h2);
    rd_chk(A_STATUS, 32'h0000_000F, 32'h9,  "w1c_bit1");

    // Disabled channel ignores toggling; enable needs two rises
    hi_len[2] = 2; lo_len[2] = 3; mode[2] = 1;
    wait_rise(2, 3, 1000, "dis_rise2");
    rd_chk(a_per(2), 32'hFFFF_FFFF, 32'h0, "dis_period2");
    rd_chk(a_hi(2),  32'hFFFF_FFFF, 32'h0, "dis_high2");
    rd_chk(A_STATUS, 32'h0000_0044, 32'h0, "dis_status2");
    mode[2] = 0;
    cycles(10);
    wr(A_CTRL, 32'hF);
    base    = rise_cnt[2];
    mode[2] = 1;
    wait_rise(2, base + 1, 1000, "en_rise_a");
    rd_chk(A_STATUS, 32'h0000_0004, 32'h0, "en_one_rise");
    wait_rise(2, base + 3, 1000, "en_rise_b");
    rd_chk(A_STATUS, 32'h0000_0004, 32'h4, "en_two_rises");
    rd_chk(a_per(2), 32'hFFFF_FFFF, 32'd5, "en_period2");
    rd_chk(a_hi(2),  32'hFFFF_FFFF, 32'd2, "en_high2");

    // Timeout on stuck-high ch0, then recovery
    mode[0] = 0;
    wr(A_CTRL, 32'hE);
    cycles(5);
    wr(A_STATUS, 32'h11);
    wr(A_CTRL, 32'hF);
    mode[0] = 2;
    cycles(50);
    rd_chk(A_STATUS, 32'h0000_0010, 32'h0,  "tmo_not_yet");
    cycles(80);
    rd_chk(A_STATUS, 32'h0000_0010, 32'h10, "tmo_flag0");
    rd_chk(A_STATUS, 32'h0000_0001, 32'h0,  "tmo_no_valid");
    rd_chk(a_per(0), 32'hFFFF_FFFF, 32'd10, "tmo_period_kept");
    rd_chk(a_hi(0),  32'hFFFF_FFFF, 32'd3,  "tmo_high_kept");
    hi_len[0] = 4; lo_len[0] = 4;
    base    = rise_cnt[0];
    mode[0] = 1;
    wait_rise(0, base + 1, 1000, "resume_rise_a");
    rd_chk(A_STATUS, 32'h0000_0001, 32'h0, "resume_one_rise");
    wait_rise(0, base + 3, 1000, "resume_rise_b");
    rd_chk(A_STATUS, 32'h0000_0001, 32'h1, "resume_valid");
    rd_chk(a_per(0), 32'hFFFF_FFFF, 32'd8, "resume_period0");
    rd_chk(a_hi(0),  32'hFFFF_FFFF, 32'd4, "resume_high0");

    // Asynchronous reset mid-measurement
    base = rise_cnt[0];
    wait_rise(0, base + 1, 1000, "arst_rise");
    cycles(2);
    #2;
    rst        = 1'b0;
    bus.addr_i = a_per(0);
    exp_q.push_back(32'h0);
    mask_q.push_back(32'hFFFF_FFFF);
    name_q.push_back("arst_period0_immediate");
    rd_vld = 1'b1;
    @(posedge clk);
    #1;
    rd_vld  = 1'b0;
    mode[0] = 0;
    rd_chk(A_STATUS, 32'hFFFF_FFFF, 32'h0, "arst_status");
    rd_chk(A_CTRL,   32'hFFFF_FFFF, 32'h0, "arst_ctrl");
    rd_chk(a_hi(2),  32'hFFFF_FFFF, 32'h0, "arst_high2");
    @(posedge clk);
    #3;
    rst = 1'b1;
    wr(A_CTRL, 32'h1);
    hi_len[0] = 6; lo_len[0] = 3;
    base    = rise_cnt[0];
    mode[0] = 1;
    wait_rise(0, base + 1, 1000, "post_rst_rise_a");
    rd_chk(A_STATUS, 32'h0000_00FF, 32'h0,  "post_rst_one_rise");
    wait_rise(0, base + 3, 1000, "post_rst_rise_b");
    rd_chk(A_STATUS, 32'h0000_00FF, 32'h1,  "post_rst_status");
    rd_chk(a_per(0), 32'hFFFF_FFFF, 32'd9,  "post_rst_period0");
    rd_chk(a_hi(0),  32'hFFFF_FFFF, 32'd6,  "post_rst_high0");

    // W1C of valid on the same edge as a new capture: set wins
    base = rise_cnt[0];
    wait_rise(0, base + 1, 1000, "race_rise");
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.we_i   = 1'b1;
    bus.addr_i = A_STATUS;
    bus.data_i = 32'h1;
    @(posedge clk);
    #1;
    bus.we_i = 1'b0;
    rd_chk(A_STATUS, 32'h0000_0001, 32'h1, "race_set_wins");
    wr(A_STATUS, 32'h1);
    rd_chk(A_STATUS, 32'h0000_0001, 32'h0, "plain_clear");

    cycles(5);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: %0d expectations unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Bus-mapped 4-channel PWM input-capture peripheral; the receive-side counterpart of the PWM generator peripheral.
- Measures the period and high time, in clk cycles, of external PWM waveforms.
- Exposes the results, valid flags and timeout flags to the core over the same write/address/data bus style as the other perips.
- Sits beside the PWM generator on the peripheral bus; its inputs come from pins.

Parameters:
- NCH, 4: number of capture channels (1..4).
- CNT_W, 32: width of the period/high counters and result registers.
- TIMEOUT, 1000000: clk cycles without a completed period before the channel aborts and flags a timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low; `RstEnable` is 1'b0.
- we_i  input  1  write enable (`WriteEnable`).
- addr_i  input  32  byte address (`MemAddrBus`).
- data_i  input  32  write data (`MemBus`).
- data_o  output  32  read data, combinational from addr_i.
- pwm_in  input  NCH  asynchronous PWM inputs, one bit per channel.

Behaviour:
- Register map, selected by addr_i[23:20] and channel field ch = addr_i[19:16]:
  - grp 0: PERIOD[ch], read-only.
  - grp 1: HIGH[ch], read-only.
  - grp 2, ch 0: CTRL, R/W; bits [NCH-1:0] are per-channel enables.
  - grp 2, ch 1: STATUS; [3:0] valid, [7:4] timeout. Write-1-to-clear.
  - Any other address reads `ZeroWord`. Writes to read-only or unmapped addresses are ignored.
- Reset (rst low, asynchronous):
  - data_o follows the decode, so it reads 0 for all registers.
  - CTRL, STATUS, PERIOD, HIGH, counters, synchronisers and every FSM go to 0 / IDLE.
- Input path per channel:
  - 2-flop synchroniser, then a registered previous value.
  - rise = s & ~s_q; fall = ~s & s_q.
- Per-channel FSM (IDLE, HIGH, LOW):
  - IDLE: cnt=0. On rise, go to HIGH with cnt=1. Waits for the first rising edge, so a partial first period is never reported.
  - HIGH: cnt++ each cycle. On fall, hcnt<=cnt and go to LOW.
  - LOW, on rise:
    - PERIOD<=cnt, HIGH<=hcnt, valid<=1.
    - cnt<=1 and go to HIGH, giving back-to-back periods with no dead cycle.
  - LOW, otherwise: cnt++.
  - A rise while in HIGH cannot occur, because the synchroniser guarantees a fall between rises.
  - Timeout, in HIGH or LOW, when cnt reaches TIMEOUT:
    - timeout flag <= 1, go to IDLE.
    - PERIOD/HIGH keep their last values.
    - This covers a stuck-high or stuck-low input.
  - The counter saturates at all-ones and never wraps; TIMEOUT must be < 2^CNT_W.
- Latency: pin rising edge to PERIOD/HIGH/valid update is 3 clk edges (2 sync + edge register; the update is on the rise cycle).
- Enable:
  - CTRL bit 0 forces the channel FSM to IDLE with cnt=0 on the next edge.
  - Results and flags are retained.
  - Re-enabling waits for a fresh rise.
- Simultaneous events:
  - A hardware set of valid/timeout in the same cycle as a W1C write of that bit: the set wins.
  - A write to CTRL takes effect the next cycle. A capture in the same cycle as disable still completes.
- Reset mid-measurement discards partial counts. There is no capture after reset until the first rise.

Decomposition:
- Shared defines: group codes (GRP_PERIOD=4'h0, GRP_HIGH=4'h1, GRP_CSR=4'h2) and CSR sub-addresses (CTRL=4'h0, STATUS=4'h1).
- FSM state encoding: IDLE=2'd0, HIGH=2'd1, LOW=2'd2.
- Reuse `RstEnable`, `WriteEnable` and `ZeroWord` from defines.v.
- Sub-module: pwm_capture_chan, instantiated NCH times.
  - Inputs: clk, rst, en, pin.
  - Outputs: period, high, cap_pulse, timeout_pulse.
  - Contains the synchroniser, edge detect, FSM and counters.
- The top holds CTRL/STATUS, the read mux and W1C logic.

Test Plan:
- Basic capture: enable ch0; drive 3 high / 7 low clk repeatedly → after the second rise, PERIOD[0]=10, HIGH[0]=3, STATUS[0]=1, exactly 3 clk after the pin edge.
- Multi-channel and W1C:
  - ch1 at 50/25 and ch3 at 4/1 → PERIOD[1]=50, HIGH[1]=25; PERIOD[3]=4, HIGH[3]=1.
  - Write STATUS=0x2 → bit 1 clears, bit 3 stays set.
- Disabled channel: CTRL=0 with ch2 toggling → PERIOD[2]/HIGH[2]=0, STATUS=0. Enable → first result only after two rises.
- Timeout: TIMEOUT=100 override, drive one rise then hold high → STATUS[4]=1 at 100 cnt, FSM in IDLE, PERIOD unchanged. Resume toggling → valid captures resume.
- Async reset mid-period: pull rst low asynchronously mid-HIGH → all reads 0 immediately. Release and resume → first result after two full rises, with correct values.
- Set/clear race: W1C write of valid in the same cycle as a new capture → valid remains 1.
